// File: rtl/map_table.sv
// Register alias table for the rename stage: speculative map, retirement map and
// per-tag ready bits, with single-cycle misprediction recovery from the retirement map.
module map_table #(
    parameter int ARF_NUM   = 32,
    parameter int ARF_IDX_W = 5,
    parameter int PRF_NUM   = 64,
    parameter int PRF_IDX_W = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 id_inst_vld_i,
    input  logic [ARF_IDX_W-1:0] id_opa_areg_i,
    input  logic [ARF_IDX_W-1:0] id_opb_areg_i,
    input  logic [ARF_IDX_W-1:0] id_dest_areg_i,
    input  logic                 id_dest_vld_i,
    input  logic [PRF_IDX_W-1:0] fl_free_tag_i,
    input  logic                 stall_dp_i,
    input  logic                 cdb_vld_i,
    input  logic [PRF_IDX_W-1:0] cdb_tag_i,
    input  logic                 rob_retire_vld_i,
    input  logic [ARF_IDX_W-1:0] rob_retire_areg_i,
    input  logic [PRF_IDX_W-1:0] rob_retire_tag_i,
    input  logic                 br_recovery_i,
    output logic [PRF_IDX_W-1:0] rat_opa_tag_o,
    output logic [PRF_IDX_W-1:0] rat_opb_tag_o,
    output logic                 rat_opa_rdy_o,
    output logic                 rat_opb_rdy_o,
    output logic [PRF_IDX_W-1:0] rat_dest_tag_o,
    output logic [PRF_IDX_W-1:0] rat_old_dest_tag_o,
    output logic                 rat_fl_pop_o
);

    logic [PRF_IDX_W-1:0] spec_map_q [ARF_NUM];
    logic [PRF_IDX_W-1:0] spec_map_d [ARF_NUM];
    logic [PRF_IDX_W-1:0] ret_map_q  [ARF_NUM];
    logic [PRF_IDX_W-1:0] ret_map_d  [ARF_NUM];
    logic [PRF_NUM-1:0]   rdy_q;
    logic [PRF_NUM-1:0]   rdy_d;

    logic fire;
    logic ren;

    assign fire = id_inst_vld_i & ~stall_dp_i & ~br_recovery_i;
    assign ren  = fire & id_dest_vld_i & (id_dest_areg_i != '0);

    // Source lookup reads the pre-update map, so a source equal to dest sees the old tag.
    always_comb begin
        rat_opa_tag_o = '0;
        rat_opb_tag_o = '0;
        rat_opa_rdy_o = 1'b1;
        rat_opb_rdy_o = 1'b1;
        if (id_opa_areg_i != '0) begin
            rat_opa_tag_o = spec_map_q[id_opa_areg_i];
            rat_opa_rdy_o = rdy_q[rat_opa_tag_o] | (cdb_vld_i & (cdb_tag_i == rat_opa_tag_o));
        end
        if (id_opb_areg_i != '0) begin
            rat_opb_tag_o = spec_map_q[id_opb_areg_i];
            rat_opb_rdy_o = rdy_q[rat_opb_tag_o] | (cdb_vld_i & (cdb_tag_i == rat_opb_tag_o));
        end
    end

    always_comb begin
        rat_fl_pop_o       = ren;
        rat_dest_tag_o     = '0;
        rat_old_dest_tag_o = '0;
        if (ren) begin
            rat_dest_tag_o     = fl_free_tag_i;
            rat_old_dest_tag_o = spec_map_q[id_dest_areg_i];
        end
    end

    // Recovery copies the retirement map including any retirement in the same cycle.
    always_comb begin
        ret_map_d = ret_map_q;
        if (rob_retire_vld_i && (rob_retire_areg_i != '0))
            ret_map_d[rob_retire_areg_i] = rob_retire_tag_i;

        spec_map_d = spec_map_q;
        if (br_recovery_i)
            spec_map_d = ret_map_d;
        else if (ren)
            spec_map_d[id_dest_areg_i] = fl_free_tag_i;

        rdy_d = rdy_q;
        if (cdb_vld_i)
            rdy_d[cdb_tag_i] = 1'b1;
        if (ren)
            rdy_d[fl_free_tag_i] = 1'b0;
    end

    for (genvar gi = 0; gi < ARF_NUM; gi++) begin : g_map
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                spec_map_q[gi] <= PRF_IDX_W'(gi);
                ret_map_q[gi]  <= PRF_IDX_W'(gi);
            end else begin
                spec_map_q[gi] <= spec_map_d[gi];
                ret_map_q[gi]  <= ret_map_d[gi];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rdy_q <= '1;
        else
            rdy_q <= rdy_d;
    end

endmodule

// File: tb/tb_map_table.sv
// Scoreboard bench for map_table: directed lookup/rename/retire/recovery vectors
// with hand-computed expectations checked by an independent monitor.
module tb_map_table;

    logic       clk;
    logic       rst;
    logic       id_inst_vld_i;
    logic [4:0] id_opa_areg_i;
    logic [4:0] id_opb_areg_i;
    logic [4:0] id_dest_areg_i;
    logic       id_dest_vld_i;
    logic [5:0] fl_free_tag_i;
    logic       stall_dp_i;
    logic       cdb_vld_i;
    logic [5:0] cdb_tag_i;
    logic       rob_retire_vld_i;
    logic [4:0] rob_retire_areg_i;
    logic [5:0] rob_retire_tag_i;
    logic       br_recovery_i;
    logic [5:0] rat_opa_tag_o;
    logic [5:0] rat_opb_tag_o;
    logic       rat_opa_rdy_o;
    logic       rat_opb_rdy_o;
    logic [5:0] rat_dest_tag_o;
    logic [5:0] rat_old_dest_tag_o;
    logic       rat_fl_pop_o;

    map_table dut (
        .clk                (clk),
        .rst                (rst),
        .id_inst_vld_i      (id_inst_vld_i),
        .id_opa_areg_i      (id_opa_areg_i),
        .id_opb_areg_i      (id_opb_areg_i),
        .id_dest_areg_i     (id_dest_areg_i),
        .id_dest_vld_i      (id_dest_vld_i),
        .fl_free_tag_i      (fl_free_tag_i),
        .stall_dp_i         (stall_dp_i),
        .cdb_vld_i          (cdb_vld_i),
        .cdb_tag_i          (cdb_tag_i),
        .rob_retire_vld_i   (rob_retire_vld_i),
        .rob_retire_areg_i  (rob_retire_areg_i),
        .rob_retire_tag_i   (rob_retire_tag_i),
        .br_recovery_i      (br_recovery_i),
        .rat_opa_tag_o      (rat_opa_tag_o),
        .rat_opb_tag_o      (rat_opb_tag_o),
        .rat_opa_rdy_o      (rat_opa_rdy_o),
        .rat_opb_rdy_o      (rat_opb_rdy_o),
        .rat_dest_tag_o     (rat_dest_tag_o),
        .rat_old_dest_tag_o (rat_old_dest_tag_o),
        .rat_fl_pop_o       (rat_fl_pop_o)
    );

    typedef struct {
        int id;
        int opa_tag;
        int opb_tag;
        int opa_rdy;
        int opb_rdy;
        int dest_tag;
        int old_tag;
        int pop;
    } exp_t;

    exp_t exp_q[$];
    logic txn_vld;
    int   checks;
    int   errors;
    int   txn_id;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int id, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL txn %0d %s: got %0d expected %0d", id, name, act, req);
        end
    endtask

    // Monitor: every presented transaction is compared against the oldest expectation.
    always @(negedge clk) begin
        if (txn_vld) begin
            if (exp_q.size() == 0) begin
                check("scoreboard_underflow", -1, 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("opa_tag",  e.id, int'(rat_opa_tag_o),      e.opa_tag);
                check("opb_tag",  e.id, int'(rat_opb_tag_o),      e.opb_tag);
                check("opa_rdy",  e.id, int'(rat_opa_rdy_o),      e.opa_rdy);
                check("opb_rdy",  e.id, int'(rat_opb_rdy_o),      e.opb_rdy);
                check("dest_tag", e.id, int'(rat_dest_tag_o),     e.dest_tag);
                check("old_tag",  e.id, int'(rat_old_dest_tag_o), e.old_tag);
                check("fl_pop",   e.id, int'(rat_fl_pop_o),       e.pop);
                $display("txn %0d: opa %0d/%0d opb %0d/%0d dest %0d old %0d pop %0d",
                         e.id, rat_opa_tag_o, rat_opa_rdy_o, rat_opb_tag_o, rat_opb_rdy_o,
                         rat_dest_tag_o, rat_old_dest_tag_o, rat_fl_pop_o);
            end
        end
    end

    // One cycle of stimulus plus its expected lookup/rename response.
    task automatic step(input int rst_v, input int opa, input int opb,
                        input int vld, input int dest, input int dvld, input int fl, input int stall,
                        input int cdbv, input int cdbt, input int retv, input int reta, input int rett,
                        input int br,
                        input int e_opa_tag, input int e_opa_rdy, input int e_opb_tag, input int e_opb_rdy,
                        input int e_dest, input int e_old, input int e_pop);
        exp_t e;
        @(posedge clk);
        #1;
        rst               = 1'(rst_v);
        id_opa_areg_i     = 5'(opa);
        id_opb_areg_i     = 5'(opb);
        id_inst_vld_i     = 1'(vld);
        id_dest_areg_i    = 5'(dest);
        id_dest_vld_i     = 1'(dvld);
        fl_free_tag_i     = 6'(fl);
        stall_dp_i        = 1'(stall);
        cdb_vld_i         = 1'(cdbv);
        cdb_tag_i         = 6'(cdbt);
        rob_retire_vld_i  = 1'(retv);
        rob_retire_areg_i = 5'(reta);
        rob_retire_tag_i  = 6'(rett);
        br_recovery_i     = 1'(br);
        e.id       = txn_id;
        e.opa_tag  = e_opa_tag;
        e.opb_tag  = e_opb_tag;
        e.opa_rdy  = e_opa_rdy;
        e.opb_rdy  = e_opb_rdy;
        e.dest_tag = e_dest;
        e.old_tag  = e_old;
        e.pop      = e_pop;
        exp_q.push_back(e);
        txn_id++;
        txn_vld = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        txn_id = 0;
        txn_vld = 1'b0;
        rst = 1'b1;
        id_inst_vld_i = 1'b0; id_opa_areg_i = '0; id_opb_areg_i = '0;
        id_dest_areg_i = '0; id_dest_vld_i = 1'b0; fl_free_tag_i = '0;
        stall_dp_i = 1'b0; cdb_vld_i = 1'b0; cdb_tag_i = '0;
        rob_retire_vld_i = 1'b0; rob_retire_areg_i = '0; rob_retire_tag_i = '0;
        br_recovery_i = 1'b0;
        repeat (2) @(posedge clk);

        //   rst opa opb vld dst dv fl st cv ct rv ra rt br | aT aR bT bR dst old pop
        // Reset state lookup
        step(0, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   5, 1, 0, 1,  0, 0, 0);
        // Rename r3 -> 40
        step(0, 1, 2, 1, 3, 1, 40, 0, 0, 0, 0, 0, 0, 0,  1, 1, 2, 1, 40, 3, 1);
        // Dependent lookup sees new tag, not ready
        step(0, 3, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   40, 0, 40, 0, 0, 0, 0);
        // CDB bypass in the broadcast cycle
        step(0, 3, 0, 0, 0, 0, 0, 0, 1, 40, 0, 0, 0, 0,  40, 1, 0, 1,  0, 0, 0);
        // Registered ready the cycle after
        step(0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   40, 1, 0, 1,  0, 0, 0);
        // Dest r0 does not rename
        step(0, 0, 3, 1, 0, 1, 45, 0, 0, 0, 0, 0, 0, 0,  0, 1, 40, 1, 0, 0, 0);
        // Stalled dispatch does not rename
        step(0, 4, 0, 1, 4, 1, 45, 1, 0, 0, 0, 0, 0, 0,  4, 1, 0, 1,  0, 0, 0);
        // Map unchanged after the non-renaming dispatches
        step(0, 4, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   4, 1, 40, 1, 0, 0, 0);
        // Rename r7 -> 41
        step(0, 7, 0, 1, 7, 1, 41, 0, 0, 0, 0, 0, 0, 0,  7, 1, 0, 1, 41, 7, 1);
        // Retire r7/41
        step(0, 7, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 41, 0,  41, 0, 0, 1, 0, 0, 0);
        // Rename r7 -> 42
        step(0, 7, 0, 1, 7, 1, 42, 0, 0, 0, 0, 0, 0, 0,  41, 0, 0, 1, 42, 41, 1);
        // Recovery with a dispatch presented: no pop
        step(0, 7, 5, 1, 5, 1, 43, 0, 0, 0, 0, 0, 0, 1,  42, 0, 5, 1,  0, 0, 0);
        // Restored map: r7 -> 41 (still pending), r3 back to 3
        step(0, 7, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   41, 0, 3, 1,  0, 0, 0);
        // r5 unaffected by the suppressed dispatch
        step(0, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   5, 1, 0, 1,  0, 0, 0);
        // Source equals dest: sources read old mapping
        step(0, 9, 9, 1, 9, 1, 50, 0, 0, 0, 0, 0, 0, 0,  9, 1, 9, 1, 50, 9, 1);
        step(0, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   50, 0, 0, 1, 0, 0, 0);
        // CDB and allocation of the same tag: the clear wins
        step(0, 0, 0, 1, 10, 1, 51, 0, 1, 51, 0, 0, 0, 0, 0, 1, 0, 1, 51, 10, 1);
        step(0, 10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  51, 0, 0, 1, 0, 0, 0);
        // Asynchronous reset mid-operation: outputs follow reset state at once
        step(1, 7, 10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  7, 1, 10, 1, 0, 0, 0);
        step(0, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   9, 1, 0, 1,  0, 0, 0);

        @(posedge clk);
        #1;
        txn_vld = 1'b0;
        repeat (2) @(posedge clk);
        check("scoreboard_drained", -1, exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
